ispm_fill_ctrl: RTL

Bulk-fill initiator for the instruction scratchpad's read/write port. It accepts a start command with a word offset and a word count, and pulls 64-bit words from a valid/ready stream. Each word is written into the ISPM through the same `dcache_req_i_t`/`dcache_req_o_t` protocol the LSU uses. An optional read-back verify checks each word after it is written. The block sits beside the LSU in front of the ISPM controller's rw port; the system arbitrates between the two. It is used for boot-time code loading and test preloading.

---
 rtl/ispm_fill_pkg.sv | 25 ++
 rtl/ispm_fill_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ispm_fill_pkg.sv
// rtl/ispm_fill_pkg.sv - ISPM rw-port request/response types shared with the LSU path
package ispm_fill_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 32;

  typedef struct packed {
    logic [DCACHE_INDEX_WIDTH-1:0] address_index;
    logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
    logic [63:0]                   data_wdata;
    logic                          data_req;
    logic                          data_we;
    logic [7:0]                    data_be;
    logic [1:0]                    data_size;
    logic                          kill_req;
    logic                          tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [63:0] data_rdata;
  } dcache_req_o_t;

endpackage

// File: rtl/ispm_fill_ctrl.sv
// rtl/ispm_fill_ctrl.sv - bulk-fill initiator writing a word stream into the ISPM rw port
module ispm_fill_ctrl
  import ispm_fill_pkg::*;
#(
  parameter int unsigned NR_WAYS        = 4,
  parameter int unsigned IDX_WIDTH      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned WAY_W         = $clog2(NR_WAYS),
  localparam int unsigned WOFF_W        = WAY_W + IDX_WIDTH - 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [WOFF_W-1:0] offset_i,
  input  logic [WOFF_W:0]   count_i,
  input  logic              verify_i,
  input  logic              wdata_valid_i,
  input  logic [63:0]       wdata_i,
  output logic              wdata_ready_o,
  output dcache_req_i_t     spm_req_o,
  input  dcache_req_o_t     spm_rsp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_timeout_o,
  output logic              err_mismatch_o,
  output logic [WOFF_W-1:0] mismatch_off_o
);

  localparam int unsigned CNT_W = WOFF_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_WRITE, ST_VERIFY, ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [WOFF_W-1:0] off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              verify_q, verify_d;
  logic [63:0]       data_q, data_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              err_to_q, err_to_d;
  logic              err_mm_q, err_mm_d;
  logic [WOFF_W-1:0] mm_off_q, mm_off_d;
  logic              finish;
  logic              req_active;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      off_q    <= '0;
      cnt_q    <= '0;
      verify_q <= 1'b0;
      data_q   <= '0;
      timer_q  <= '0;
      err_to_q <= 1'b0;
      err_mm_q <= 1'b0;
      mm_off_q <= '0;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      verify_q <= verify_d;
      data_q   <= data_d;
      timer_q  <= timer_d;
      err_to_q <= err_to_d;
      err_mm_q <= err_mm_d;
      mm_off_q <= mm_off_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    verify_d = verify_q;
    data_d   = data_q;
    timer_d  = '0;
    err_to_d = err_to_q;
    err_mm_d = err_mm_q;
    mm_off_d = mm_off_q;
    finish   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          err_to_d = 1'b0;
          err_mm_d = 1'b0;
          mm_off_d = '0;
          if (count_i != '0) begin
            off_d    = offset_i;
            cnt_d    = count_i;
            verify_d = verify_i;
            state_d  = ST_FETCH;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        if (wdata_valid_i) begin
          data_d  = wdata_i;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (spm_rsp_i.data_gnt) begin
          if (verify_q) state_d = ST_VERIFY;
          else          finish  = 1'b1;
        end else if (timer_q == TMR_LAST) begin
          err_to_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          timer_d  = timer_q + TMR_W'(1);
        end
      end
      ST_VERIFY: begin
        if (spm_rsp_i.data_rvalid) begin
          // Only the first mismatch since start is recorded
          if (spm_rsp_i.data_rdata != data_q && !err_mm_q) begin
            err_mm_d = 1'b1;
            mm_off_d = off_q;
          end
          finish = 1'b1;
        end else if (timer_q == TMR_LAST) begin
          err_to_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          timer_d  = timer_q + TMR_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      off_d   = off_q + WOFF_W'(1);
      cnt_d   = cnt_q - CNT_W'(1);
      state_d = (cnt_q == CNT_W'(1)) ? ST_DONE : ST_FETCH;
    end
  end

  assign req_active = (state_q == ST_WRITE) || (state_q == ST_VERIFY);

  // Request fields are gated so the port is all-zero whenever no request is driven
  always_comb begin
    spm_req_o = '0;
    if (req_active) begin
      spm_req_o.data_req                     = 1'b1;
      spm_req_o.data_we                      = (state_q == ST_WRITE);
      spm_req_o.data_be                      = 8'hFF;
      spm_req_o.data_size                    = 2'b11;
      spm_req_o.address_index[IDX_WIDTH-1:0] = {off_q[IDX_WIDTH-4:0], 3'b000};
      spm_req_o.address_tag[WAY_W-1:0]       = off_q[WOFF_W-1 -: WAY_W];
      spm_req_o.data_wdata                   = data_q;
    end
  end

  assign wdata_ready_o  = (state_q == ST_FETCH);
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);
  assign err_timeout_o  = err_to_q;
  assign err_mismatch_o = err_mm_q;
  assign mismatch_off_o = mm_off_q;

endmodule
